load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage downstream of the ALU in the RV32I datapath: takes ALU result as address, RD2 as store data.
//  Runs byte/half/word loads/stores over a word-wide req/ack data bus; stalls the core (PC/regfile write) until done.
//  Returns aligned, sign/zero-extended load data for the WD mux; flags bus timeout and (optionally) misalignment.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles bus_req waits for bus_ack before abort (>=1)
//  CNT_W           5   width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk         in   1   core clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  mem_read    in   1   current instruction is a load
//  mem_write   in   1   current instruction is a store (wins if both high)
//  func3       in   3   instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr        in   32  byte address (ALU result)
//  store_data  in   32  RD2
//  load_data   out  32  extended load result, valid while done=1
//  stall       out  1   hold PC and suppress wereg
//  done        out  1   one-cycle pulse: access finished (or aborted)
//  bus_err     out  1   with done: timeout or illegal func3
//  misalign    out  1   with done: misaligned access (LSU_MISALIGN_TRAP_EN only)
//  bus_req     out  1   bus request, held until bus_ack or timeout
//  bus_we      out  1   1 = write
//  bus_addr    out  32  {addr[31:2],2'b00}
//  bus_be      out  4   byte enables (writes; reads return full word)
//  bus_wdata   out  32  store data replicated to lanes
//  bus_ack     in   1   bus completion, sampled on clk edge while bus_req=1
//  bus_rdata   in   32  read word, valid with bus_ack
// BEHAVIOUR
//  Reset (async): state IDLE, cnt 0, all outputs 0 incl. bus_req; mid-transfer reset drops bus_req immediately.
//  FSM: IDLE -> BUS -> DONE -> IDLE; IDLE -> DONE directly on error check.
//  IDLE: request = mem_read|mem_write; stall = request (combinational, same cycle). Latch addr/data/func3/we on edge.
//   Illegal func3 (011,110,111) or trapped misalign -> DONE with bus_err/misalign, no bus cycle.
//  BUS: bus_req=1, outputs from latched values, stall=1; cnt++ each cycle.
//   bus_ack -> DONE, capture bus_rdata. cnt==TIMEOUT_CYCLES-1 w/o ack -> DONE, bus_err=1, load_data=0.
//  DONE: stall=0, done=1 for exactly one cycle; core advances on this edge; next state IDLE.
//   New request is only accepted in IDLE (next instruction appears the cycle after DONE).
//  Lanes: off=addr[1:0]. B: be=0001<<off, wdata={4{sd[7:0]}}; H: be=0011<<{off[1],1'b0}, wdata={2{sd[15:0]}}; W: 1111.
//  Load: byte=rdata[8*off+:8], half=rdata[16*off[1]+:16]; B/H sign-extend, BU/HU zero-extend, W as is.
//  Reads drive bus_be=1111. Store load_data=0. Latency: 2 + wait cycles (ack in first BUS cycle -> 3-cycle access).
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> no bus cycle, DONE with misalign=1,
//   load_data=0, no bus write. Undefined: misalign tied 0; low addr bits truncated per size (H uses off[1], W none).
// STRUCTURE
//  lsu_pkg: func3 encodings (F3_B..F3_HU), state enum (IDLE/BUS/DONE), default TIMEOUT_CYCLES.
//  Sub-module lsu_align: combinational be/wdata generation and load extract/extend; FSM+counter stay in top.
// TESTING
//  SW addr=0x100 sd=0xDEADBEEF, ack 1st cycle -> be=1111, wdata=0xDEADBEEF, done at cycle 3, stall 2 cycles.
//  LB addr=0x203 rdata=0x80112233 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x202 -> 0x00008011.
//  SB addr=0x101 sd=0x000000A5 -> bus_addr=0x100, be=0010, wdata=0xA5A5A5A5.
//  No ack, TIMEOUT_CYCLES=4 -> bus_req 4 cycles then done+bus_err, load_data=0, bus_req low.
//  LW addr=0x102: with LSU_MISALIGN_TRAP_EN -> no bus_req, done+misalign next cycle; without -> reads 0x100.
//  Assert rst during BUS -> bus_req/stall/done 0 before next edge; func3=011 load -> done+bus_err, no bus_req.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the RV32I load/store unit.
package lsu_pkg;

    localparam int unsigned LSU_TIMEOUT_CYCLES = 16;
    localparam int unsigned LSU_DATA_W         = 32;
    localparam int unsigned LSU_BE_W           = LSU_DATA_W / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Encodings with no defined access size.
    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Halfword on odd byte or word off a word boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extract / extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]            func3,
    input  logic [1:0]            off,
    input  logic [LSU_DATA_W-1:0] store_data,
    input  logic [LSU_DATA_W-1:0] rdata,
    output logic [LSU_BE_W-1:0]   be_c,
    output logic [LSU_DATA_W-1:0] wdata_c,
    output logic [LSU_DATA_W-1:0] ldata_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: size comes from func3[1:0], unsigned variants alias signed ones.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = store_data;
        case (func3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_c    = off[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = store_data;
            end
        endcase
    end

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        ldata_c = '0;
        case (func3)
            F3_B:    ldata_c = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ldata_c = {{16{half_sel[15]}}, half_sel};
            F3_W:    ldata_c = rdata;
            F3_BU:   ldata_c = {24'd0, byte_sel};
            F3_HU:   ldata_c = {16'd0, half_sel};
            default: ldata_c = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: req/ack bus master with timeout, stalls the core until done.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            func3,
    input  logic [LSU_DATA_W-1:0] addr,
    input  logic [LSU_DATA_W-1:0] store_data,
    output logic [LSU_DATA_W-1:0] load_data,
    output logic                  stall,
    output logic                  done,
    output logic                  bus_err,
    output logic                  misalign,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [LSU_DATA_W-1:0] bus_addr,
    output logic [LSU_BE_W-1:0]   bus_be,
    output logic [LSU_DATA_W-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [LSU_DATA_W-1:0] bus_rdata
);

    lsu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LSU_DATA_W-1:0] addr_q, sd_q, ld_q;
    logic [2:0]            f3_q;
    logic                  we_q, err_q;
    logic                  request_c, take_c, fin_c, fin_err_c;
    logic [LSU_DATA_W-1:0] fin_ld_c;
    logic [LSU_BE_W-1:0]   be_c;
    logic [LSU_DATA_W-1:0] wdata_c, ldata_c;

    lsu_align u_align (
        .func3      (f3_q),
        .off        (addr_q[1:0]),
        .store_data (sd_q),
        .rdata      (bus_rdata),
        .be_c       (be_c),
        .wdata_c    (wdata_c),
        .ldata_c    (ldata_c)
    );

    assign request_c = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, fin_mis_c;
`endif

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        take_c    = 1'b0;
        fin_c     = 1'b0;
        fin_err_c = 1'b0;
        fin_ld_c  = '0;
        stall     = 1'b0;
        done      = 1'b0;
        bus_req   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        fin_mis_c = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                stall = request_c;
                cnt_d = '0;
                if (request_c) begin
                    take_c = 1'b1;
                    if (is_illegal_f3(func3)) begin
                        state_d   = DONE;
                        fin_c     = 1'b1;
                        fin_err_c = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    end else if (is_misaligned(func3, addr[1:0])) begin
                        state_d   = DONE;
                        fin_c     = 1'b1;
                        fin_mis_c = 1'b1;
`endif
                    end else begin
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_ack) begin
                    state_d  = DONE;
                    fin_c    = 1'b1;
                    fin_ld_c = we_q ? '0 : ldata_c;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    fin_c     = 1'b1;
                    fin_err_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture in IDLE; result held for the DONE cycle only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            sd_q   <= '0;
            f3_q   <= '0;
            we_q   <= 1'b0;
            ld_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (take_c) begin
                addr_q <= addr;
                sd_q   <= store_data;
                f3_q   <= func3;
                we_q   <= mem_write;
            end
            if (fin_c) begin
                ld_q  <= fin_ld_c;
                err_q <= fin_err_c;
            end else if (state_q == DONE) begin
                ld_q  <= '0;
                err_q <= 1'b0;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (fin_c) begin
            mis_q <= fin_mis_c;
        end else if (state_q == DONE) begin
            mis_q <= 1'b0;
        end
    end
    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    assign load_data = ld_q;
    assign bus_err   = err_q;
    assign bus_we    = (state_q == BUS) & we_q;
    assign bus_addr  = (state_q == BUS) ? {addr_q[31:2], 2'b00} : '0;
    assign bus_be    = (state_q == BUS) ? (we_q ? be_c : 4'b1111) : '0;
    assign bus_wdata = (state_q == BUS) & we_q ? wdata_c : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a size/offset arithmetic model.
module tb_load_store_unit;

    localparam int unsigned TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, store_data, load_data;
    logic        stall, done, bus_err, misalign, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .func3(func3), .addr(addr), .store_data(store_data), .load_data(load_data),
        .stall(stall), .done(done), .bus_err(bus_err), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: expected loaded value from the word, size and offset.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned off, b, h;
        off = a % 4;
        b = (rd >> (8 * off)) % 256;
        h = (rd >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd1: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd2: return rd;
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    // One complete access; entered and left just after a rising edge.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd,
                              input int ack_at, output logic [31:0] ld_seen);
        int size, off, nbus, cyc, nreq, nstall, done_cyc;
        logic ill, mis, to_err;
        logic [31:0] exp_be, exp_wd, exp_ld;
        size   = int'(f3 % 4);
        off    = int'(a % 4);
        ill    = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        mis    = TRAP && !ill && ((size == 1 && off % 2 == 1) || (size == 2 && off != 0));
        to_err = !ill && !mis && ack_at >= int'(TO);
        nbus   = (ill || mis) ? 0 : (to_err ? int'(TO) : ack_at + 1);
        if (!we)            exp_be = 32'hF;
        else if (size == 0) exp_be = 32'(1) << off;
        else if (size == 1) exp_be = 32'(3) << (2 * (off / 2));
        else                exp_be = 32'hF;
        if (size == 0)      exp_wd = (sd % 256) * 32'h01010101;
        else if (size == 1) exp_wd = (sd % 65536) * 32'h00010001;
        else                exp_wd = sd;
        exp_ld = (we || ill || mis || to_err) ? 32'd0 : ref_load(f3, a, rd);

        mem_write = we; mem_read = !we; func3 = f3; addr = a; store_data = sd;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        #1 check("stall_on_request", 32'(stall), 32'd1);
        cyc = 0; nreq = 0; nstall = 0; done_cyc = -1; ld_seen = 32'd0;
        while (done_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (stall) nstall++;
            if (bus_req) begin
                nreq++;
                if (nreq == 1) begin
                    check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                    check("bus_we", 32'(bus_we), 32'(we));
                    check("bus_be", 32'(bus_be), exp_be);
                    if (we) check("bus_wdata", bus_wdata, exp_wd);
                end
                bus_ack   = (nreq - 1 == ack_at);
                bus_rdata = rd;
            end else begin
                bus_ack = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                ld_seen  = load_data;
                check("load_data", load_data, exp_ld);
                check("bus_err", 32'(bus_err), 32'(ill || to_err));
                check("misalign", 32'(misalign), 32'(mis));
                check("stall_at_done", 32'(stall), 32'd0);
            end
        end
        check("done_cycle", 32'(done_cyc), 32'(nbus + 2));
        check("bus_req_cycles", 32'(nreq), 32'(nbus));
        check("stall_cycles", 32'(nstall), 32'(nbus + 1));
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ld;

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'd0;
        addr = 32'd0; store_data = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        #2;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        run_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'd0, 0, ld);
        run_access(1'b0, 3'd0, 32'h203, 32'd0, 32'h80112233, 0, ld);
        check("lb_value", ld, 32'hFFFFFF80);
        run_access(1'b0, 3'd4, 32'h203, 32'd0, 32'h80112233, 1, ld);
        check("lbu_value", ld, 32'h00000080);
        run_access(1'b0, 3'd5, 32'h202, 32'd0, 32'h80112233, 2, ld);
        check("lhu_value", ld, 32'h00008011);
        run_access(1'b1, 3'd0, 32'h101, 32'h000000A5, 32'd0, 0, ld);
        run_access(1'b0, 3'd2, 32'h100, 32'd0, 32'h12345678, int'(TO), ld);
        run_access(1'b0, 3'd2, 32'h102, 32'd0, 32'hCAFEF00D, 0, ld);
        run_access(1'b0, 3'd3, 32'h100, 32'd0, 32'h11111111, 0, ld);
        run_access(1'b1, 3'd1, 32'h103, 32'h0000BEEF, 32'd0, 1, ld);

        // Reset in the middle of a bus cycle.
        mem_read = 1'b1; func3 = 3'd2; addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_bus_req", 32'(bus_req), 32'd1);
        #2 rst = 1'b1; mem_read = 1'b0;
        #1;
        check("mid_rst_bus_req", 32'(bus_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                       $urandom(), $urandom(), int'($urandom_range(0, TO + 1)), ld);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
